// File: rtl/ramp_decoder.sv
// Receive-side ramp pattern checker: recovers the ramp step (deltaY), locks on a
// run of consistent legal steps, counts steps while locked and flags illegal steps and wraps.
module ramp_decoder #(
    parameter int unsigned LOCK_N = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dec_enb,
    input  logic        sample_valid,
    input  logic [11:0] sample,
    output logic [1:0]  y_code,
    output logic        locked,
    output logic [11:0] step_count,
    output logic        wrap_pulse,
    output logic        err_pulse,
    output logic        err_sticky
);

    localparam int DATA_W = 12;

    typedef enum logic [1:0] {IDLE, FIRST, ACQUIRE, LOCKED} state_t;

    state_t            state;
    logic [DATA_W-1:0] prev;
    logic [1:0]        cand;
    logic [3:0]        acq_cnt;

    logic [DATA_W-1:0] diff;
    logic [1:0]        code;
    logic              is_hold;
    logic              is_legal;
    logic              is_wrap;
    logic [3:0]        acq_next;

    // Legal ramp steps map to a nonzero Y code; everything else returns 00.
    function automatic logic [1:0] classify(input logic [DATA_W-1:0] d);
        case (d)
            12'd1:    return 2'b01;
            12'd16:   return 2'b10;
            12'd1290: return 2'b11;
            default:  return 2'b00;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] v);
        return (v == {DATA_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    always_comb begin
        diff     = sample - prev;
        code     = classify(diff);
        is_hold  = (diff == '0);
        is_legal = (code != 2'b00);
        is_wrap  = (sample < prev);
        acq_next = (code == cand) ? acq_cnt + 4'd1 : 4'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            prev       <= '0;
            cand       <= '0;
            acq_cnt    <= '0;
            y_code     <= '0;
            locked     <= 1'b0;
            step_count <= '0;
            wrap_pulse <= 1'b0;
            err_pulse  <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            wrap_pulse <= 1'b0;
            err_pulse  <= 1'b0;
            if (!dec_enb) begin
                state      <= IDLE;
                prev       <= '0;
                cand       <= '0;
                acq_cnt    <= '0;
                y_code     <= '0;
                locked     <= 1'b0;
                step_count <= '0;
                err_sticky <= 1'b0;
            end else begin
                case (state)
                    IDLE: state <= FIRST;
                    FIRST: begin
                        if (sample_valid) begin
                            prev  <= sample;
                            state <= ACQUIRE;
                        end
                    end
                    ACQUIRE: begin
                        if (sample_valid) begin
                            prev <= sample;
                            if (is_legal) begin
                                wrap_pulse <= is_wrap;
                                cand       <= code;
                                if (acq_next == 4'(LOCK_N)) begin
                                    state      <= LOCKED;
                                    locked     <= 1'b1;
                                    y_code     <= code;
                                    step_count <= 12'(LOCK_N);
                                    acq_cnt    <= '0;
                                end else begin
                                    acq_cnt <= acq_next;
                                end
                            end else if (!is_hold) begin
                                err_pulse  <= 1'b1;
                                err_sticky <= 1'b1;
                                acq_cnt    <= '0;
                            end
                        end
                    end
                    LOCKED: begin
                        if (sample_valid) begin
                            prev <= sample;
                            if (is_legal && code == y_code) begin
                                step_count <= sat_inc(step_count);
                                wrap_pulse <= is_wrap;
                            end else if (!is_hold) begin
                                // Any disagreement drops lock; cand keeps the old code.
                                err_pulse  <= 1'b1;
                                err_sticky <= 1'b1;
                                locked     <= 1'b0;
                                y_code     <= '0;
                                step_count <= '0;
                                acq_cnt    <= '0;
                                state      <= ACQUIRE;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ramp_decoder.sv
// Scoreboard bench for ramp_decoder: the driver queues the expected outputs for each
// driven cycle, and a monitor pops and compares one entry after every clock edge.
module tb_ramp_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        dec_enb;
    logic        sample_valid;
    logic [11:0] sample;
    logic [1:0]  y_code;
    logic        locked;
    logic [11:0] step_count;
    logic        wrap_pulse;
    logic        err_pulse;
    logic        err_sticky;

    typedef struct packed {
        logic [1:0]  y;
        logic        lk;
        logic [11:0] sc;
        logic        wr;
        logic        er;
        logic        st;
    } exp_t;

    typedef struct {
        exp_t  e;
        string n;
    } item_t;

    item_t q[$];
    int    checks   = 0;
    int    failures = 0;

    ramp_decoder #(.LOCK_N(4)) dut (
        .clk(clk), .rst_n(rst_n), .dec_enb(dec_enb), .sample_valid(sample_valid),
        .sample(sample), .y_code(y_code), .locked(locked), .step_count(step_count),
        .wrap_pulse(wrap_pulse), .err_pulse(err_pulse), .err_sticky(err_sticky)
    );

    always #8 clk = ~clk;

    function automatic exp_t mk(input logic [1:0] y, input logic lk, input logic [11:0] sc,
                                input logic wr, input logic er, input logic st);
        exp_t x;
        x.y = y; x.lk = lk; x.sc = sc; x.wr = wr; x.er = er; x.st = st;
        return x;
    endfunction

    function automatic exp_t actual();
        return mk(y_code, locked, step_count, wrap_pulse, err_pulse, err_sticky);
    endfunction

    task automatic compare(input string n, input exp_t a, input exp_t e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: got y=%b lk=%b sc=%0d wr=%b er=%b st=%b, want y=%b lk=%b sc=%0d wr=%b er=%b st=%b",
                     n, a.y, a.lk, a.sc, a.wr, a.er, a.st, e.y, e.lk, e.sc, e.wr, e.er, e.st);
        end
    endtask

    task automatic drive(input logic e, input logic v, input logic [11:0] s,
                         input exp_t x, input string n);
        item_t it;
        @(negedge clk);
        dec_enb      = e;
        sample_valid = v;
        sample       = s;
        it.e = x;
        it.n = n;
        q.push_back(it);
    endtask

    // Monitor: one expected entry per clock edge while the driver is active.
    initial begin
        item_t it;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                it = q.pop_front();
                compare(it.n, actual(), it.e);
            end
        end
    end

    initial begin
        exp_t z, s1;
        exp_t x;
        logic [11:0] scv;
        logic [11:0] sv;
        z  = mk(2'b00, 1'b0, 12'd0, 1'b0, 1'b0, 1'b0);
        s1 = mk(2'b00, 1'b0, 12'd0, 1'b0, 1'b0, 1'b1);

        rst_n = 1'b0; dec_enb = 1'b0; sample_valid = 1'b0; sample = '0;
        #20;
        compare("reset_state", actual(), z);
        @(negedge clk);
        rst_n = 1'b1;

        // Y=11 lock with wrap on 1064
        drive(1, 0, 0,    z, "y11_idle");
        drive(1, 1, 0,    z, "y11_first");
        drive(1, 1, 1290, z, "y11_s1");
        drive(1, 1, 2580, z, "y11_s2");
        drive(1, 1, 3870, z, "y11_s3");
        drive(1, 1, 1064, mk(2'b11, 1, 12'd4, 1, 0, 0), "y11_lock_wrap");
        drive(1, 0, 1064, mk(2'b11, 1, 12'd4, 0, 0, 0), "y11_pulse_drop");
        drive(0, 1, 1065, z, "disable_prio");

        // Y=01 with holds, then a +16 step while locked at 01
        drive(1, 0, 0,  z, "y01_idle");
        drive(1, 1, 10, z, "y01_first");
        drive(1, 1, 10, z, "y01_hold1");
        drive(1, 1, 11, z, "y01_s1");
        drive(1, 1, 11, z, "y01_hold2");
        drive(1, 1, 12, z, "y01_s2");
        drive(1, 1, 13, z, "y01_s3");
        drive(1, 1, 14, mk(2'b01, 1, 12'd4, 0, 0, 0), "y01_lock");
        drive(1, 1, 15, mk(2'b01, 1, 12'd5, 0, 0, 0), "y01_count5");
        drive(1, 1, 15, mk(2'b01, 1, 12'd5, 0, 0, 0), "y01_locked_hold");
        drive(1, 1, 31, mk(2'b00, 0, 12'd0, 0, 1, 1), "y01_code_change");
        drive(0, 0, 0,  z, "disable_clears_sticky");

        // Y=10 lock, then +1 code change while locked
        drive(1, 0, 0,  z, "y10_idle");
        drive(1, 1, 0,  z, "y10_first");
        drive(1, 1, 16, z, "y10_s1");
        drive(1, 1, 32, z, "y10_s2");
        drive(1, 1, 48, z, "y10_s3");
        drive(1, 1, 64, mk(2'b10, 1, 12'd4, 0, 0, 0), "y10_lock");
        drive(1, 1, 65, mk(2'b00, 0, 12'd0, 0, 1, 1), "y10_plus1_err");
        drive(1, 0, 65, s1, "y10_err_drop");

        // Illegal +7 in ACQUIRE restarts the run
        drive(1, 1, 81,  s1, "acq_s1");
        drive(1, 1, 97,  s1, "acq_s2");
        drive(1, 1, 104, mk(2'b00, 0, 12'd0, 0, 1, 1), "acq_plus7_err");
        drive(1, 1, 120, s1, "acq_r1");
        drive(1, 1, 136, s1, "acq_r2");
        drive(1, 1, 152, s1, "acq_r3");
        drive(1, 1, 168, mk(2'b10, 1, 12'd4, 0, 0, 1), "acq_relock");
        drive(1, 1, 175, mk(2'b00, 0, 12'd0, 0, 1, 1), "b2b_err1");
        drive(1, 1, 182, mk(2'b00, 0, 12'd0, 0, 1, 1), "b2b_err2");
        drive(1, 1, 100, mk(2'b00, 0, 12'd0, 0, 1, 1), "illegal_backstep_no_wrap");
        drive(0, 0, 0,   z, "disable2");

        // Saturation: 5000 +1 steps at Y=01
        drive(1, 0, 0, z, "sat_idle");
        drive(1, 1, 0, z, "sat_first");
        for (int i = 1; i <= 5000; i++) begin
            sv  = 12'(i % 4096);
            scv = (i >= 4095) ? 12'hFFF : 12'(i);
            if (i < 4) x = z;
            else       x = mk(2'b01, 1, scv, (i % 4096 == 0) ? 1'b1 : 1'b0, 0, 0);
            drive(1, 1, sv, x, "sat_step");
        end
        drive(1, 0, 12'd904, mk(2'b01, 1, 12'hFFF, 0, 0, 0), "sat_idle_valid0");
        drive(0, 0, 0, z, "disable_locked");

        // Async reset while locked, checked between clock edges
        drive(1, 0, 0, z, "ar_idle");
        drive(1, 1, 0, z, "ar_first");
        drive(1, 1, 1, z, "ar_s1");
        drive(1, 1, 2, z, "ar_s2");
        drive(1, 1, 3, z, "ar_s3");
        drive(1, 1, 4, mk(2'b01, 1, 12'd4, 0, 0, 0), "ar_lock");
        drive(1, 0, 4, mk(2'b01, 1, 12'd4, 0, 0, 0), "ar_hold");
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        compare("async_reset", actual(), z);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 0, 0, z, "post_reset_idle");

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
